// File: rtl/serial_addnb_if.sv
// Operand/result bundle for the digit-serial adder: requester drives start and operands,
// the adder returns busy/done and the registered result flags.
interface serial_addnb_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] r;
   logic             co;
   logic             ov;

   modport master (
      output start, a, b, ci, sub,
      input  busy, done, r, co, ov
   );

   modport slave (
      input  start, a, b, ci, sub,
      output busy, done, r, co, ov
   );
endinterface

// File: rtl/serial_addnb.sv
// Digit-serial add/sub: WIDTH/DIGIT edges from the accepting edge to the done pulse.
// No backpressure: start is only taken while idle, the result is held until the next completion.
module serial_addnb #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_addnb_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("serial_addnb: WIDTH must be a nonzero multiple of DIGIT");
   end

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sa, sa_nxt;
   logic [WIDTH-1:0] sb, sb_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic             carry, carry_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] r_q, r_nxt;
   logic             co_q, co_nxt;
   logic             ov_q, ov_nxt;
   logic             done_q, done_nxt;

   logic [DIGIT:0]       slice;
   logic                 msb_cin;
   logic [WIDTH+DIGIT-1:0] acc_wide;

   // One DIGIT-wide full-adder slice; carry into its top bit recovered from sum ^ operands.
   always_comb begin
      slice    = {1'b0, sa[DIGIT-1:0]} + {1'b0, sb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
      msb_cin  = slice[DIGIT-1] ^ sa[DIGIT-1] ^ sb[DIGIT-1];
      acc_wide = {slice[DIGIT-1:0], acc};
   end

   always_comb begin
      state_nxt = state;
      sa_nxt    = sa;
      sb_nxt    = sb;
      acc_nxt   = acc;
      carry_nxt = carry;
      cnt_nxt   = cnt;
      r_nxt     = r_q;
      co_nxt    = co_q;
      ov_nxt    = ov_q;
      done_nxt  = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               sa_nxt    = bus.a;
               sb_nxt    = bus.sub ? ~bus.b : bus.b;
               carry_nxt = bus.sub ? 1'b1 : bus.ci;
               cnt_nxt   = '0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            // LSB digit first: each new digit enters at the top and slides down.
            acc_nxt   = acc_wide[WIDTH+DIGIT-1:DIGIT];
            sa_nxt    = sa >> DIGIT;
            sb_nxt    = sb >> DIGIT;
            carry_nxt = slice[DIGIT];
            cnt_nxt   = cnt + CW'(1);
            if (cnt == CW'(N - 1)) begin
               r_nxt     = acc_wide[WIDTH+DIGIT-1:DIGIT];
               co_nxt    = slice[DIGIT];
               ov_nxt    = slice[DIGIT] ^ msb_cin;
               done_nxt  = 1'b1;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         r_q    <= '0;
         co_q   <= 1'b0;
         ov_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         sa     <= sa_nxt;
         sb     <= sb_nxt;
         acc    <= acc_nxt;
         carry  <= carry_nxt;
         cnt    <= cnt_nxt;
         r_q    <= r_nxt;
         co_q   <= co_nxt;
         ov_q   <= ov_nxt;
         done_q <= done_nxt;
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.done = done_q;
   assign bus.r    = r_q;
   assign bus.co   = co_q;
   assign bus.ov   = ov_q;
endmodule

// File: tb/tb_serial_addnb.sv
// Bench for serial_addnb in three shapes: 1/1, 8/1 and 8/4 (WIDTH/DIGIT).
module tb_serial_addnb;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2:0] start_v = '0;
   logic [7:0] a_v = '0, b_v = '0;
   logic       ci_v = 1'b0, sub_v = 1'b0;

   serial_addnb_if #(.WIDTH(1)) if0 ();
   serial_addnb_if #(.WIDTH(8)) if1 ();
   serial_addnb_if #(.WIDTH(8)) if2 ();

   serial_addnb #(.WIDTH(1), .DIGIT(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   serial_addnb #(.WIDTH(8), .DIGIT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   serial_addnb #(.WIDTH(8), .DIGIT(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

   assign if0.start = start_v[0];
   assign if0.a     = a_v[0];
   assign if0.b     = b_v[0];
   assign if0.ci    = ci_v;
   assign if0.sub   = sub_v;
   assign if1.start = start_v[1];
   assign if1.a     = a_v;
   assign if1.b     = b_v;
   assign if1.ci    = ci_v;
   assign if1.sub   = sub_v;
   assign if2.start = start_v[2];
   assign if2.a     = a_v;
   assign if2.b     = b_v;
   assign if2.ci    = ci_v;
   assign if2.sub   = sub_v;

   logic [2:0] dn, bz, cov, ovv;
   logic [7:0] rr [3];
   assign dn  = {if2.done, if1.done, if0.done};
   assign bz  = {if2.busy, if1.busy, if0.busy};
   assign cov = {if2.co, if1.co, if0.co};
   assign ovv = {if2.ov, if1.ov, if0.ov};
   assign rr[0] = {7'b0, if0.r};
   assign rr[1] = if1.r;
   assign rr[2] = if2.r;

   int nd [3] = '{1, 8, 2};

   typedef struct {
      int         d;
      logic [7:0] r;
      logic       co;
      logic       ov;
      int         done_cyc;
   } exp_t;
   exp_t sb_q [$];

   typedef struct {
      int         d;
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic       sub;
      logic [7:0] r;
      logic       co;
      logic       ov;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] last_r [3] = '{8'h0, 8'h0, 8'h0};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Advance to the next falling edge and retire any completed results.
   task automatic tick();
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         if (dn[d]) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL spurious_done dut%0d: done=1 at cycle %0d, required none", d, cyc);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk($sformatf("done_dut%0d", d), d, e.d);
               chk($sformatf("r_dut%0d", d), rr[d], e.r);
               chk($sformatf("co_dut%0d", d), cov[d], e.co);
               chk($sformatf("ov_dut%0d", d), ovv[d], e.ov);
               chk($sformatf("latency_dut%0d", d), cyc, e.done_cyc);
               last_r[d] = e.r;
            end
         end
      end
   endtask

   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic ci, input logic sub);
      logic [7:0] bb;
      logic [8:0] s9;
      logic       ov;
      bb = sub ? ~b : b;
      s9 = {1'b0, a} + {1'b0, bb} + {8'b0, (sub ? 1'b1 : ci)};
      ov = (a[7] == bb[7]) && (s9[7] != a[7]);
      return {ov, s9[8], s9[7:0]};
   endfunction

   task automatic drive(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sub,
                        input logic [7:0] er, input logic eco, input logic eov);
      exp_t e;
      a_v = a; b_v = b; ci_v = ci; sub_v = sub;
      start_v[d] = 1'b1;
      e.d = d; e.r = er; e.co = eco; e.ov = eov; e.done_cyc = cyc + 1 + nd[d];
      sb_q.push_back(e);
      tick();
      start_v[d] = 1'b0;
   endtask

   task automatic wait_empty(input int budget);
      for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout: %0d results outstanding, required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   vec_t vecs [14];

   initial begin
      vecs[0]  = '{0, 8'h0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0};
      vecs[1]  = '{0, 8'h0, 8'h0, 1'b1, 1'b0, 8'h1, 1'b0, 1'b1};
      vecs[2]  = '{0, 8'h0, 8'h1, 1'b0, 1'b0, 8'h1, 1'b0, 1'b0};
      vecs[3]  = '{0, 8'h0, 8'h1, 1'b1, 1'b0, 8'h0, 1'b1, 1'b0};
      vecs[4]  = '{0, 8'h1, 8'h0, 1'b0, 1'b0, 8'h1, 1'b0, 1'b0};
      vecs[5]  = '{0, 8'h1, 8'h0, 1'b1, 1'b0, 8'h0, 1'b1, 1'b0};
      vecs[6]  = '{0, 8'h1, 8'h1, 1'b0, 1'b0, 8'h0, 1'b1, 1'b1};
      vecs[7]  = '{0, 8'h1, 8'h1, 1'b1, 1'b0, 8'h1, 1'b1, 1'b0};
      vecs[8]  = '{1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[9]  = '{1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[10] = '{1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[11] = '{1, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
      vecs[12] = '{1, 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
      vecs[13] = '{2, 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0};

      repeat (3) tick();
      rst_n = 1'b1;
      for (int d = 0; d < 3; d++)
         chk($sformatf("reset_state_dut%0d", d), {bz[d], dn[d], cov[d], ovv[d], rr[d]}, 32'h0);

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub,
               vecs[i].r, vecs[i].co, vecs[i].ov);
         wait_empty(nd[vecs[i].d] + 4);
      end

      // start held high: three results, done pulses 9 cycles apart
      begin
         int k;
         exp_t e;
         k = cyc;
         a_v = 8'h12; b_v = 8'h34; ci_v = 1'b0; sub_v = 1'b0;
         start_v[1] = 1'b1;
         for (int j = 1; j <= 3; j++) begin
            e.d = 1; e.r = 8'h46; e.co = 1'b0; e.ov = 1'b0; e.done_cyc = k + 9 * j;
            sb_q.push_back(e);
         end
         wait_empty(40);
         start_v[1] = 1'b0;
         repeat (12) tick();
         chk("held_start_idle_busy", bz[1], 1'b0);
      end

      // start during a run is ignored and r holds the previous value
      drive(1, 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
      repeat (2) tick();
      a_v = 8'hFF; b_v = 8'hFF; start_v[1] = 1'b1;
      tick();
      start_v[1] = 1'b0;
      chk("busy_during_run", bz[1], 1'b1);
      chk("r_stable_during_run", rr[1], last_r[1]);
      wait_empty(12);
      repeat (12) tick();

      // synchronous reset mid-run discards the operation
      drive(1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sb_q.delete();
      chk("midrun_reset_outputs", {bz[1], dn[1], cov[1], ovv[1], rr[1]}, 32'h0);
      repeat (12) tick();
      chk("midrun_reset_no_done", dn[1], 1'b0);
      drive(1, 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
      wait_empty(12);

      for (int d = 1; d <= 2; d++) begin
         for (int i = 0; i < (d == 1 ? 200 : 1000); i++) begin
            logic [7:0] ra, rb;
            logic       rci, rsub;
            logic [9:0] m;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rci = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            m = model(ra, rb, rci, rsub);
            drive(d, ra, rb, rci, rsub, m[7:0], m[8], m[9]);
            wait_empty(nd[d] + 4);
         end
      end

      repeat (4) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
